seg_display_arbiter: RTL and testbench

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

---
 rtl/seg_display_arbiter_if.sv | 21 ++
 rtl/seg_display_arbiter.sv | 117 +++++++++++
 tb/tb_seg_display_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_arbiter_if.sv
// rtl/seg_display_arbiter_if.sv - request/data/grant bundle between display sources and the arbiter
interface seg_display_arbiter_if;
    logic [2:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] data2;
    logic [2:0]  gnt;
    logic [15:0] dout;
    logic        busy;
    logic        switch_pulse;

    modport master (
        output req, data0, data1, data2,
        input  gnt, dout, busy, switch_pulse
    );

    modport slave (
        input  req, data0, data1, data2,
        output gnt, dout, busy, switch_pulse
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin arbiter sharing one seven-segment display among three sources
module seg_display_arbiter #(
    parameter logic [15:0] HOLD  = 16'd50000,
    parameter logic [15:0] BLANK = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_display_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t      state, next_state;
    logic [1:0]  last, next_last;
    logic [15:0] cnt, next_cnt;
    logic [2:0]  next_gnt;
    logic [15:0] next_dout;
    logic [1:0]  c0, c1, winner;
    logic        found;
    logic        expired;
    logic [2:0]  gnt_q;
    logic [15:0] dout_q;
    logic        busy_q;
    logic        pulse_q;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // In OWN, last is always the current owner, so it doubles as the owner index.
    always_comb begin
        c0     = inc3(last);
        c1     = inc3(c0);
        found  = 1'b1;
        winner = last;
        if (bus.req[c0])
            winner = c0;
        else if (bus.req[c1])
            winner = c1;
        else if (bus.req[last])
            winner = last;
        else
            found = 1'b0;
    end

    assign expired = (cnt == HOLD - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 2'd2;
            cnt     <= 16'd0;
            gnt_q   <= 3'b000;
            dout_q  <= BLANK;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state   <= next_state;
            last    <= next_last;
            cnt     <= next_cnt;
            gnt_q   <= next_gnt;
            dout_q  <= next_dout;
            busy_q  <= (next_state == OWN);
            pulse_q <= (next_gnt != gnt_q);
        end
    end

    always_comb begin
        next_state = state;
        next_last  = last;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    next_state = OWN;
                    next_last  = winner;
                    next_cnt   = 16'd0;
                end
            end
            OWN: begin
                if (!bus.req[last]) begin
                    next_cnt = 16'd0;
                    if (found)
                        next_last = winner;
                    else
                        next_state = IDLE;
                end else if (expired && found && winner != last) begin
                    next_last = winner;
                    next_cnt  = 16'd0;
                end else if (!expired) begin
                    next_cnt = cnt + 16'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // dout is chosen from the next-state owner so it lands in the same cycle as gnt.
    always_comb begin
        next_gnt  = 3'b000;
        next_dout = BLANK;
        if (next_state == OWN) begin
            case (next_last)
                2'd0: begin next_gnt = 3'b001; next_dout = bus.data0; end
                2'd1: begin next_gnt = 3'b010; next_dout = bus.data1; end
                2'd2: begin next_gnt = 3'b100; next_dout = bus.data2; end
                default: ;
            endcase
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.dout         = dout_q;
    assign bus.busy         = busy_q;
    assign bus.switch_pulse = pulse_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - randomized and directed bench for seg_display_arbiter (HOLD=4 and HOLD=1)
module tb_seg_display_arbiter;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    seg_display_arbiter_if if4();
    seg_display_arbiter_if if1();

    seg_display_arbiter #(.HOLD(16'd4), .BLANK(16'hFFFF)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    seg_display_arbiter #(.HOLD(16'd1), .BLANK(16'hFFFF)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          owner;
        int          last;
        int          age;
        logic [2:0]  gnt;
        logic [15:0] dout;
        logic        busy;
        logic        pulse;
    } model_t;

    model_t m4, m1;

    function automatic model_t model_reset();
        model_t m;
        m.owner = -1;
        m.last  = 2;
        m.age   = 0;
        m.gnt   = 3'b000;
        m.dout  = 16'hFFFF;
        m.busy  = 1'b0;
        m.pulse = 1'b0;
        return m;
    endfunction

    // age counts owned cycles including the current one; the hold has run out once age reaches hold.
    function automatic model_t model_step(model_t m, int hold, logic [2:0] r,
                                          logic [15:0] d0, logic [15:0] d1, logic [15:0] d2);
        model_t      n;
        int          pick;
        int          nxt;
        logic [15:0] d [3];
        n    = m;
        pick = -1;
        d[0] = d0;
        d[1] = d1;
        d[2] = d2;
        for (int k = 1; k <= 3; k++)
            if (pick < 0 && r[(m.last + k) % 3]) pick = (m.last + k) % 3;
        if (m.owner < 0 || !r[m.owner]) begin
            nxt   = pick;
            n.age = 1;
        end else if (m.age >= hold && pick >= 0 && pick != m.owner) begin
            nxt   = pick;
            n.age = 1;
        end else begin
            nxt   = m.owner;
            n.age = m.age + 1;
        end
        n.owner = nxt;
        if (nxt >= 0) n.last = nxt;
        n.gnt   = (nxt < 0) ? 3'b000 : 3'(1 << nxt);
        n.dout  = (nxt < 0) ? 16'hFFFF : d[nxt];
        n.busy  = (nxt >= 0);
        n.pulse = (n.gnt != m.gnt);
        return n;
    endfunction

    task automatic drive_cycle(input logic [2:0] r, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c);
        if4.req = r; if4.data0 = a; if4.data1 = b; if4.data2 = c;
        if1.req = r; if1.data0 = a; if1.data1 = b; if1.data2 = c;
        m4 = model_step(m4, 4, r, a, b, c);
        m1 = model_step(m1, 1, r, a, b, c);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if4.req = 3'b111; if4.data0 = 16'h1111; if4.data1 = 16'h2222; if4.data2 = 16'h3333;
        if1.req = 3'b111; if1.data0 = 16'h1111; if1.data1 = 16'h2222; if1.data2 = 16'h3333;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({if4.gnt, if4.busy, if4.switch_pulse} !== 5'b0)
            $display("FAIL reset_ctl got=%b exp=00000", {if4.gnt, if4.busy, if4.switch_pulse});
        checks++;
        if (if4.dout !== 16'hFFFF) $display("FAIL reset_dout got=%h exp=ffff", if4.dout);
        checks++;
        if ({if1.gnt, if1.busy, if1.switch_pulse} !== 5'b0)
            $display("FAIL reset_ctl_h1 got=%b exp=00000", {if1.gnt, if1.busy, if1.switch_pulse});
        failures += ({if4.gnt, if4.busy, if4.switch_pulse} !== 5'b0) + (if4.dout !== 16'hFFFF)
                  + ({if1.gnt, if1.busy, if1.switch_pulse} !== 5'b0);
        rst_n = 1'b1;
        m4 = model_reset();
        m1 = model_reset();
    endtask

    task automatic test_rotate();
        logic [15:0] d0, d1, d2;
        logic [2:0]  exp;
        logic        exp_p;
        d0 = 16'($urandom); d1 = 16'($urandom); d2 = 16'($urandom);
        for (int i = 1; i <= 12; i++) begin
            drive_cycle(3'b111, d0, d1, d2);
            exp   = (i <= 4) ? 3'b001 : (i <= 8) ? 3'b010 : 3'b100;
            exp_p = (i == 1 || i == 5 || i == 9);
            checks++;
            if (if4.gnt !== exp) begin
                failures++;
                $display("FAIL rotate_gnt cyc=%0d got=%b exp=%b", i, if4.gnt, exp);
            end
            checks++;
            if (if4.switch_pulse !== exp_p) begin
                failures++;
                $display("FAIL rotate_pulse cyc=%0d got=%b exp=%b", i, if4.switch_pulse, exp_p);
            end
            if (i == 1) begin
                checks++;
                if (if4.dout !== d0) begin
                    failures++;
                    $display("FAIL rotate_first_dout got=%h exp=%h", if4.dout, d0);
                end
            end
            checks++;
            if ({if1.gnt, if1.dout, if1.busy, if1.switch_pulse} !== {m1.gnt, m1.dout, m1.busy, m1.pulse}) begin
                failures++;
                $display("FAIL rotate_h1 cyc=%0d got=%b/%h exp=%b/%h", i, if1.gnt, if1.dout, m1.gnt, m1.dout);
            end
        end
    endtask

    task automatic test_follow();
        drive_cycle(3'b001, 16'h1234, 16'h0, 16'h0);
        checks++;
        if (if4.gnt !== 3'b001 || if4.switch_pulse !== 1'b1) begin
            failures++;
            $display("FAIL follow_take got=%b/%b exp=001/1", if4.gnt, if4.switch_pulse);
        end
        for (int i = 0; i < 8; i++) begin
            logic [15:0] v;
            v = (i < 4) ? 16'h1234 : 16'hABCD;
            drive_cycle(3'b001, v, 16'h0, 16'h0);
            checks++;
            if ({if4.gnt, if4.dout, if4.switch_pulse} !== {3'b001, v, 1'b0}) begin
                failures++;
                $display("FAIL follow_data cyc=%0d got=%b/%h/%b exp=001/%h/0", i, if4.gnt, if4.dout,
                         if4.switch_pulse, v);
            end
        end
    endtask

    task automatic test_release_early();
        drive_cycle(3'b000, 16'h0, 16'h0, 16'h0);
        drive_cycle(3'b001, 16'h0A0A, 16'h0, 16'h0C0C);
        drive_cycle(3'b001, 16'h0A0A, 16'h0, 16'h0C0C);
        checks++;
        if (if4.gnt !== 3'b001) begin
            failures++;
            $display("FAIL release_pre got=%b exp=001", if4.gnt);
        end
        drive_cycle(3'b100, 16'h0A0A, 16'h0, 16'h0C0C);
        checks++;
        if ({if4.gnt, if4.switch_pulse, if4.dout} !== {3'b100, 1'b1, 16'h0C0C}) begin
            failures++;
            $display("FAIL release_early got=%b/%b/%h exp=100/1/0c0c", if4.gnt, if4.switch_pulse, if4.dout);
        end
    endtask

    task automatic test_all_drop();
        drive_cycle(3'b000, 16'h5555, 16'h6666, 16'h7777);
        checks++;
        if ({if4.gnt, if4.busy, if4.dout, if4.switch_pulse} !== {3'b000, 1'b0, 16'hFFFF, 1'b1}) begin
            failures++;
            $display("FAIL all_drop got=%b/%b/%h/%b exp=000/0/ffff/1", if4.gnt, if4.busy, if4.dout,
                     if4.switch_pulse);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(3'b011, 16'h1, 16'h2, 16'h3);
        drive_cycle(3'b011, 16'h1, 16'h2, 16'h3);
        checks++;
        if (if4.busy !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre got=%b exp=1", if4.busy);
        end
        #2;
        rst_n = 1'b0;
        if4.req = 3'b000;
        if1.req = 3'b000;
        #1;
        checks++;
        if ({if4.gnt, if4.dout, if4.busy} !== {3'b000, 16'hFFFF, 1'b0}) begin
            failures++;
            $display("FAIL areset_clear got=%b/%h/%b exp=000/ffff/0", if4.gnt, if4.dout, if4.busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m4 = model_reset();
        m1 = model_reset();
        drive_cycle(3'b110, 16'h1, 16'h2, 16'h3);
        checks++;
        if ({if4.gnt, if4.dout} !== {3'b010, 16'h2}) begin
            failures++;
            $display("FAIL areset_first got=%b/%h exp=010/0002", if4.gnt, if4.dout);
        end
    endtask

    task automatic test_hold1();
        drive_cycle(3'b000, 16'h0, 16'h0, 16'h0);
        for (int i = 1; i <= 8; i++) begin
            logic [2:0] exp;
            drive_cycle(3'b101, 16'hA0A0, 16'hB0B0, 16'hC0C0);
            exp = (i % 2 == 1) ? 3'b100 : 3'b001;
            checks++;
            if ({if1.gnt, if1.switch_pulse} !== {exp, 1'b1}) begin
                failures++;
                $display("FAIL hold1_alt cyc=%0d got=%b/%b exp=%b/1", i, if1.gnt, if1.switch_pulse, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 3'($urandom);
            drive_cycle(r, 16'($urandom), 16'($urandom), 16'($urandom));
            checks++;
            if ({if4.gnt, if4.dout, if4.busy, if4.switch_pulse} !== {m4.gnt, m4.dout, m4.busy, m4.pulse}) begin
                failures++;
                $display("FAIL random_h4 cyc=%0d got=%b/%h/%b/%b exp=%b/%h/%b/%b", i, if4.gnt, if4.dout,
                         if4.busy, if4.switch_pulse, m4.gnt, m4.dout, m4.busy, m4.pulse);
            end
            checks++;
            if ({if1.gnt, if1.dout, if1.busy, if1.switch_pulse} !== {m1.gnt, m1.dout, m1.busy, m1.pulse}) begin
                failures++;
                $display("FAIL random_h1 cyc=%0d got=%b/%h/%b/%b exp=%b/%h/%b/%b", i, if1.gnt, if1.dout,
                         if1.busy, if1.switch_pulse, m1.gnt, m1.dout, m1.busy, m1.pulse);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_rotate();
        test_follow();
        test_release_early();
        test_all_drop();
        test_async_reset();
        test_hold1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
